hazard_ctrl: RTL and testbench

- Pipeline hazard and sequencing controller for the 5-stage MIPS32 core.
- Drives the hold/flush controls of the IF/ID register, the PC hold, and the ID/EX bubble insertion.
- Handles load-use stalls, taken-branch and jump flushes, and a multi-cycle mult/div unit (MDU) busy window.
- Sits beside the ID stage; all control outputs are combinational from current state plus same-cycle inputs so the pipeline registers sample them on the same clk edge.

---
 rtl/hazard_ctrl_if.sv | 46 ++++
 rtl/hazard_ctrl.sv | 124 ++++++++++++
 tb/tb_hazard_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the ID-stage decode/EX-stage resolve logic and
// the hazard controller. The master side is the pipeline (drives the
// instruction fields), the slave side is hazard_ctrl (drives the controls).
// These are plain level signals, not a valid/ready handshake: every control
// output is valid in the same cycle as the ID/EX fields that produce it, and
// the pipeline registers sample it on the next rising clk edge.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    // ID-stage instruction fields
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             id_jump;
    logic             id_is_mdu;
    logic             id_reads_hilo;
    // EX-stage feedback
    logic             ex_mem_read;
    logic [4:0]       ex_rt;
    logic             ex_branch_taken;
    // pipeline controls
    logic             pc_hold;
    logic             ifid_hold;
    logic             ifid_flush;
    logic             idex_flush;
    logic             mdu_start;
    logic             mdu_busy;
    logic [CNT_W-1:0] stall_cycles;
    // debug view of the controller FSM (1 = MDU window active)
    logic             state_dbg;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump, id_is_mdu,
               id_reads_hilo, ex_mem_read, ex_rt, ex_branch_taken,
        input  pc_hold, ifid_hold, ifid_flush, idex_flush, mdu_start,
               mdu_busy, stall_cycles, state_dbg
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump, id_is_mdu,
               id_reads_hilo, ex_mem_read, ex_rt, ex_branch_taken,
        output pc_hold, ifid_hold, ifid_flush, idex_flush, mdu_start,
               mdu_busy, stall_cycles, state_dbg
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS32 pipeline.
// Detects load-use and mult/div (MDU) hazards, generates PC/IF-ID holds,
// IF/ID and ID/EX flushes, issues MDU ops and tracks the MDU busy window.
// Control outputs are combinational from the current state plus the
// same-cycle ID/EX inputs so the pipeline registers act on the next edge.
module hazard_ctrl #(
    parameter int MDU_LATENCY = 4,   // MDU busy cycles after issue, 2..15
    parameter int CNT_W       = 16   // width of stall-cycle counter
) (
    input  logic         clk,
    input  logic         reset,      // synchronous, active-low
    hazard_ctrl_if.slave bus
);

    typedef enum logic {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } state_t;

    localparam logic [3:0] MDU_LOAD = 4'(MDU_LATENCY - 1);

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       mdu_cnt;
    logic [3:0]       mdu_cnt_nxt;
    logic [CNT_W-1:0] stall_cnt;

    logic load_use;
    logic mdu_hz;
    logic stall;
    logic issue;

    // Hazard detection: register 0 never carries a dependency.
    always_comb begin
        load_use = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
                   ((bus.id_uses_rs && (bus.id_rs == bus.ex_rt)) ||
                    (bus.id_uses_rt && (bus.id_rt == bus.ex_rt)));
        mdu_hz   = (state == MDU_BUSY) && (bus.id_is_mdu || bus.id_reads_hilo);
        stall    = load_use || mdu_hz;
        // In RUN mdu_hz is 0, so a load-use stall is the only thing that can
        // hold back an MDU issue besides a wrong-path (branch) flush.
        issue    = reset && (state == RUN) && bus.id_is_mdu &&
                   !bus.ex_branch_taken && !load_use;
    end

    // Prioritised pipeline controls: reset, branch flush, stall, jump.
    always_comb begin
        bus.pc_hold    = 1'b0;
        bus.ifid_hold  = 1'b0;
        bus.ifid_flush = 1'b0;
        bus.idex_flush = 1'b0;
        bus.mdu_start  = 1'b0;
        bus.mdu_busy   = 1'b0;
        if (!reset) begin
            // Keep the pipeline full of NOPs while reset is held.
            bus.ifid_flush = 1'b1;
            bus.idex_flush = 1'b1;
        end else begin
            bus.mdu_start = issue;
            bus.mdu_busy  = (state == MDU_BUSY);
            if (bus.ex_branch_taken) begin
                // ID holds a wrong-path instruction: squash it, ignore its hazards.
                bus.ifid_flush = 1'b1;
                bus.idex_flush = 1'b1;
            end else if (stall) begin
                bus.pc_hold    = 1'b1;
                bus.ifid_hold  = 1'b1;
                bus.idex_flush = 1'b1;
            end else if (bus.id_jump) begin
                bus.ifid_flush = 1'b1;
            end
        end
    end

    // Next-state logic for the MDU window FSM and its down-counter.
    always_comb begin
        state_nxt   = state;
        mdu_cnt_nxt = mdu_cnt;
        case (state)
            RUN: begin
                if (issue) begin
                    state_nxt   = MDU_BUSY;
                    mdu_cnt_nxt = MDU_LOAD;
                end
            end
            MDU_BUSY: begin
                // A branch flush does not cancel an op already in flight.
                if (mdu_cnt == 4'd0) begin
                    state_nxt = RUN;
                end else begin
                    mdu_cnt_nxt = mdu_cnt - 4'd1;
                end
            end
            default: begin
                state_nxt   = RUN;
                mdu_cnt_nxt = 4'd0;
            end
        endcase
    end

    // FSM state and MDU counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= RUN;
            mdu_cnt <= 4'd0;
        end else begin
            state   <= state_nxt;
            mdu_cnt <= mdu_cnt_nxt;
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (bus.pc_hold && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign bus.stall_cycles = stall_cnt;
    assign bus.state_dbg    = (state == MDU_BUSY);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural model
// that tracks "busy cycles remaining" and a saturating stall count.
module tb_hazard_ctrl;

    localparam int LAT    = 4;
    localparam int CNT_W  = 5;
    localparam int CNT_MX = (1 << CNT_W) - 1;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

    hazard_ctrl #(.MDU_LATENCY(LAT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (hif.slave)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    int busy_left;   // busy cycles still to come in the current MDU window
    int stall_cnt;

    initial begin
        busy_left = 0;
        stall_cnt = 0;
    end

    always @(negedge clk) begin
        logic lu, busy, hz, e_ph, e_ih, e_if, e_xf, e_st, e_bz;
        lu   = hif.ex_mem_read && (hif.ex_rt != 0) &&
               ((hif.id_uses_rs && hif.id_rs == hif.ex_rt) ||
                (hif.id_uses_rt && hif.id_rt == hif.ex_rt));
        busy = (busy_left > 0);
        hz   = busy && (hif.id_is_mdu || hif.id_reads_hilo);
        {e_ph, e_ih, e_if, e_xf} = 4'b0000;
        if (!reset)                   {e_ph, e_ih, e_if, e_xf} = 4'b0011;
        else if (hif.ex_branch_taken) {e_ph, e_ih, e_if, e_xf} = 4'b0011;
        else if (lu || hz)            {e_ph, e_ih, e_if, e_xf} = 4'b1101;
        else if (hif.id_jump)         {e_ph, e_ih, e_if, e_xf} = 4'b0010;
        e_st = reset && !busy && hif.id_is_mdu && !hif.ex_branch_taken && !lu;
        e_bz = reset && busy;

        chk("pc_hold",      32'(hif.pc_hold),      32'(e_ph));
        chk("ifid_hold",    32'(hif.ifid_hold),    32'(e_ih));
        chk("ifid_flush",   32'(hif.ifid_flush),   32'(e_if));
        chk("idex_flush",   32'(hif.idex_flush),   32'(e_xf));
        chk("mdu_start",    32'(hif.mdu_start),    32'(e_st));
        chk("mdu_busy",     32'(hif.mdu_busy),     32'(e_bz));
        chk("stall_cycles", 32'(hif.stall_cycles), 32'(stall_cnt));

        // advance model to what the next rising edge produces
        if (!reset) begin
            busy_left = 0;
            stall_cnt = 0;
        end else begin
            if (busy_left > 0) busy_left--;
            if (e_st) busy_left = LAT;
            if (e_ph && stall_cnt < CNT_MX) stall_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        hif.id_rs = 5'd0;  hif.id_rt = 5'd0;
        hif.id_uses_rs = 1'b0; hif.id_uses_rt = 1'b0;
        hif.id_jump = 1'b0; hif.id_is_mdu = 1'b0; hif.id_reads_hilo = 1'b0;
        hif.ex_mem_read = 1'b0; hif.ex_rt = 5'd0; hif.ex_branch_taken = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic set_load_use();
        hif.ex_mem_read = 1'b1; hif.ex_rt = 5'd8;
        hif.id_rs = 5'd8; hif.id_uses_rs = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        set_idle();
        tick();
        @(negedge clk);
        chk("rst_ifid_flush", 32'(hif.ifid_flush), 32'd1);
        chk("rst_pc_hold",    32'(hif.pc_hold),    32'd0);
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_count", 32'(hif.stall_cycles), 32'd0);

        // load-use stall
        tick();
        set_load_use();
        @(negedge clk);
        chk("lu_pc_hold", 32'(hif.pc_hold), 32'd1);
        tick();
        set_idle();
        @(negedge clk);
        chk("lu_count", 32'(hif.stall_cycles), 32'd1);
        // r0 never a hazard
        tick();
        set_load_use();
        hif.ex_rt = 5'd0; hif.id_rs = 5'd0;
        @(negedge clk);
        chk("r0_no_stall", 32'(hif.pc_hold), 32'd0);
        // branch over a hazard
        tick();
        set_load_use();
        hif.ex_branch_taken = 1'b1;
        @(negedge clk);
        chk("br_pc_hold",    32'(hif.pc_hold),    32'd0);
        chk("br_idex_flush", 32'(hif.idex_flush), 32'd1);
        tick();
        set_idle();
        @(negedge clk);
        chk("br_count", 32'(hif.stall_cycles), 32'd1);

        // MDU window with mfhi waiting on it
        do_reset();
        set_idle();
        hif.id_is_mdu = 1'b1;
        @(negedge clk);
        chk("mdu_start_c0", 32'(hif.mdu_start), 32'd1);
        for (int c = 1; c <= 4; c++) begin
            tick();
            hif.id_is_mdu = 1'b0; hif.id_reads_hilo = 1'b1;
            @(negedge clk);
            chk("hilo_hold", 32'(hif.pc_hold), 32'd1);
            chk("hilo_busy", 32'(hif.mdu_busy), 32'd1);
        end
        tick();
        @(negedge clk);
        chk("hilo_release", 32'(hif.pc_hold),      32'd0);
        chk("hilo_count",   32'(hif.stall_cycles), 32'd4);

        // back-to-back mult
        tick();
        do_reset();
        set_idle();
        hif.id_is_mdu = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            if (c == 6) hif.id_is_mdu = 1'b0;
            @(negedge clk);
            chk("b2b_start", 32'(hif.mdu_start), (c == 0 || c == 5) ? 32'd1 : 32'd0);
            chk("b2b_busy",  32'(hif.mdu_busy),  ((c >= 1 && c <= 4) || (c >= 6 && c <= 9)) ? 32'd1 : 32'd0);
            tick();
        end

        // jumps
        set_idle();
        hif.id_jump = 1'b1;
        @(negedge clk);
        chk("jmp_ifid_flush", 32'(hif.ifid_flush), 32'd1);
        chk("jmp_idex_flush", 32'(hif.idex_flush), 32'd0);
        tick();
        set_load_use();
        @(negedge clk);
        chk("jmp_lu_flush", 32'(hif.ifid_flush), 32'd0);
        chk("jmp_lu_hold",  32'(hif.ifid_hold),  32'd1);

        // reset in the middle of an MDU window
        tick();
        set_idle();
        hif.id_is_mdu = 1'b1;
        tick();
        hif.id_is_mdu = 1'b0;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(hif.mdu_busy), 32'd0);
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy_after", 32'(hif.mdu_busy),     32'd0);
        chk("midrst_count",      32'(hif.stall_cycles), 32'd0);

        // saturation
        tick();
        set_load_use();
        for (int c = 0; c < CNT_MX + 6; c++) tick();
        @(negedge clk);
        chk("sat_count", 32'(hif.stall_cycles), 32'(CNT_MX));

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            tick();
            reset              = ($urandom_range(0, 63) != 0);
            hif.id_rs          = 5'($urandom_range(0, 3));
            hif.id_rt          = 5'($urandom_range(0, 3));
            hif.ex_rt          = 5'($urandom_range(0, 3));
            hif.id_uses_rs     = 1'($urandom_range(0, 1));
            hif.id_uses_rt     = 1'($urandom_range(0, 1));
            hif.ex_mem_read    = ($urandom_range(0, 9) < 4);
            hif.id_jump        = ($urandom_range(0, 9) < 2);
            hif.id_is_mdu      = ($urandom_range(0, 9) < 3);
            hif.id_reads_hilo  = ($urandom_range(0, 9) < 3);
            hif.ex_branch_taken = ($urandom_range(0, 9) < 2);
        end
        tick();
        set_idle();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
